// File: rtl/ext_bus_arbiter_pkg.sv
// Shared types and constants for the external bus arbiter.
// Holds the arbiter state encoding, bus width and wait-counter helpers.
package ext_bus_arbiter_pkg;

    localparam int BUS_WIDTH    = 16;
    localparam int WAIT_W       = 4;
    localparam int ARB_MAX_WAIT = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_PEND = 2'd1,
        ARB_HOLD = 2'd2,
        ARB_ACK  = 2'd3
    } arb_state_t;

    // Saturating increment keeps the wait counter pinned at 15.
    function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/ext_bus_arbiter_register.sv
// Loadable data register with synchronous active-high clear.
// Used for the request address/data latches and the read-data capture.
module register #(
    parameter int BUS_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 LOAD,
    input  logic [BUS_WIDTH-1:0] D,
    output logic [BUS_WIDTH-1:0] Q
);

    logic [BUS_WIDTH-1:0] data_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            data_q <= '0;
        end else if (LOAD) begin
            data_q <= D;
        end
    end

    assign Q = data_q;

endmodule

// File: rtl/ext_bus_arbiter.sv
// Shares the external memory bus between the core (priority) and one
// secondary master; starved requests park the core via a hold handshake.
module ext_bus_arbiter
    import ext_bus_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [BUS_WIDTH-1:0] CORE_ADDR,
    input  logic [BUS_WIDTH-1:0] CORE_DOUT,
    input  logic                 CORE_RDN,
    input  logic                 CORE_WRN0,
    input  logic                 CORE_WRN1,
    input  logic                 CORE_STOPPED,
    input  logic                 CORE_HELD,
    output logic                 CORE_HOLD,
    input  logic                 EXT_REQ,
    input  logic                 EXT_WE,
    input  logic [1:0]           EXT_BE,
    input  logic [BUS_WIDTH-1:0] EXT_ADDR,
    input  logic [BUS_WIDTH-1:0] EXT_WDATA,
    output logic                 EXT_ACK,
    output logic [BUS_WIDTH-1:0] EXT_RDATA,
    input  logic [BUS_WIDTH-1:0] MEM_DIN,
    output logic [BUS_WIDTH-1:0] MEM_ADDR,
    output logic [BUS_WIDTH-1:0] MEM_DOUT,
    output logic                 MEM_RDN,
    output logic                 MEM_WRN0,
    output logic                 MEM_WRN1,
    output logic                 ABUS_OEN,
    output logic                 GRANT
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    arb_state_t           state_q, state_d;
    logic [WAIT_W-1:0]    cnt_q, cnt_d;
    logic                 hold_q, hold_d;
    logic                 we_q;
    logic [1:0]           be_q;
    logic [BUS_WIDTH-1:0] req_addr_q;
    logic [BUS_WIDTH-1:0] req_wdata_q;

    logic core_idle;
    logic accept;
    logic grant;
    logic rdata_load;

    assign core_idle  = CORE_RDN & CORE_WRN0 & CORE_WRN1;
    assign accept     = (state_q == ARB_IDLE) && EXT_REQ;
    assign rdata_load = grant && !we_q;

    register #(.BUS_WIDTH(BUS_WIDTH)) u_addr_reg (
        .CLK   (CLK),
        .RESET (RESET),
        .LOAD  (accept),
        .D     (EXT_ADDR),
        .Q     (req_addr_q)
    );

    register #(.BUS_WIDTH(BUS_WIDTH)) u_wdata_reg (
        .CLK   (CLK),
        .RESET (RESET),
        .LOAD  (accept),
        .D     (EXT_WDATA),
        .Q     (req_wdata_q)
    );

    register #(.BUS_WIDTH(BUS_WIDTH)) u_rdata_reg (
        .CLK   (CLK),
        .RESET (RESET),
        .LOAD  (rdata_load),
        .D     (MEM_DIN),
        .Q     (EXT_RDATA)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            hold_q  <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            if (accept) begin
                we_q <= EXT_WE;
                be_q <= EXT_BE;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (EXT_REQ) begin
                    state_d = ARB_PEND;
                    cnt_d   = '0;
                end
            end
            ARB_PEND: begin
                if (grant) begin
                    state_d = ARB_ACK;
                end else begin
                    cnt_d = wait_inc(cnt_q);
                    if (cnt_q == WAIT_LAST) begin
                        state_d = ARB_HOLD;
                    end
                end
            end
            ARB_HOLD: begin
                if (grant) begin
                    state_d = ARB_ACK;
                end
            end
            ARB_ACK: state_d = ARB_IDLE;
            default: state_d = ARB_IDLE;
        endcase
        // Registering the next-state decode keeps CORE_HOLD glitch-free.
        hold_d = (state_d == ARB_HOLD);
    end

    always_comb begin
        grant = 1'b0;
        case (state_q)
            ARB_PEND: grant = core_idle;
            ARB_HOLD: grant = core_idle | CORE_HELD;
            default:  grant = 1'b0;
        endcase

        MEM_ADDR = CORE_ADDR;
        MEM_DOUT = CORE_DOUT;
        MEM_RDN  = CORE_RDN;
        MEM_WRN0 = CORE_WRN0;
        MEM_WRN1 = CORE_WRN1;
        if (grant) begin
            MEM_ADDR = req_addr_q;
            MEM_DOUT = req_wdata_q;
            MEM_RDN  = we_q;
            MEM_WRN0 = !(we_q && be_q[0]);
            MEM_WRN1 = !(we_q && be_q[1]);
        end
    end

    assign GRANT     = grant;
    assign CORE_HOLD = hold_q;
    assign EXT_ACK   = (state_q == ARB_ACK);
    assign ABUS_OEN  = CORE_STOPPED & ~grant;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Directed self-checking bench for ext_bus_arbiter (MAX_WAIT = 4).
module tb_ext_bus_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] CORE_ADDR, CORE_DOUT;
    logic        CORE_RDN, CORE_WRN0, CORE_WRN1;
    logic        CORE_STOPPED, CORE_HELD, CORE_HOLD;
    logic        EXT_REQ, EXT_WE;
    logic [1:0]  EXT_BE;
    logic [15:0] EXT_ADDR, EXT_WDATA, EXT_RDATA;
    logic        EXT_ACK;
    logic [15:0] MEM_DIN, MEM_ADDR, MEM_DOUT;
    logic        MEM_RDN, MEM_WRN0, MEM_WRN1, ABUS_OEN, GRANT;

    int vec = 0;
    int err = 0;

    always #5 CLK = ~CLK;

    ext_bus_arbiter #(.MAX_WAIT(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .CORE_ADDR(CORE_ADDR), .CORE_DOUT(CORE_DOUT),
        .CORE_RDN(CORE_RDN), .CORE_WRN0(CORE_WRN0), .CORE_WRN1(CORE_WRN1),
        .CORE_STOPPED(CORE_STOPPED), .CORE_HELD(CORE_HELD), .CORE_HOLD(CORE_HOLD),
        .EXT_REQ(EXT_REQ), .EXT_WE(EXT_WE), .EXT_BE(EXT_BE),
        .EXT_ADDR(EXT_ADDR), .EXT_WDATA(EXT_WDATA),
        .EXT_ACK(EXT_ACK), .EXT_RDATA(EXT_RDATA),
        .MEM_DIN(MEM_DIN), .MEM_ADDR(MEM_ADDR), .MEM_DOUT(MEM_DOUT),
        .MEM_RDN(MEM_RDN), .MEM_WRN0(MEM_WRN0), .MEM_WRN1(MEM_WRN1),
        .ABUS_OEN(ABUS_OEN), .GRANT(GRANT)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; CORE_ADDR = 16'hCAFE; CORE_DOUT = 16'h1111;
        CORE_RDN = 1'b1; CORE_WRN0 = 1'b1; CORE_WRN1 = 1'b1;
        CORE_STOPPED = 1'b1; CORE_HELD = 1'b0;
        EXT_REQ = 1'b0; EXT_WE = 1'b0; EXT_BE = 2'b00;
        EXT_ADDR = '0; EXT_WDATA = '0; MEM_DIN = 16'h0000;
        tick(); tick(); #3;
        vec++; if (CORE_HOLD !== 1'b0) begin err++; $display("FAIL rst_hold: got %b want 0", CORE_HOLD); end
        vec++; if (EXT_ACK !== 1'b0) begin err++; $display("FAIL rst_ack: got %b want 0", EXT_ACK); end
        vec++; if (EXT_RDATA !== 16'h0000) begin err++; $display("FAIL rst_rdata: got %h want 0000", EXT_RDATA); end
        vec++; if (GRANT !== 1'b0) begin err++; $display("FAIL rst_grant: got %b want 0", GRANT); end
        vec++; if (MEM_ADDR !== 16'hCAFE || MEM_DOUT !== 16'h1111) begin err++; $display("FAIL rst_pass: got %h/%h want cafe/1111", MEM_ADDR, MEM_DOUT); end
        vec++; if ({MEM_RDN, MEM_WRN1, MEM_WRN0} !== 3'b111) begin err++; $display("FAIL rst_strobes: got %b want 111", {MEM_RDN, MEM_WRN1, MEM_WRN0}); end
        vec++; if (ABUS_OEN !== 1'b1) begin err++; $display("FAIL rst_oen: got %b want 1", ABUS_OEN); end
        tick(); RESET = 1'b0; CORE_STOPPED = 1'b0; #3;
        vec++; if (ABUS_OEN !== 1'b0) begin err++; $display("FAIL rst_oen_run: got %b want 0", ABUS_OEN); end
    endtask

    task automatic test_idle_read();
        tick(); EXT_REQ = 1'b1; EXT_WE = 1'b0; EXT_ADDR = 16'h1234; MEM_DIN = 16'hBEEF; #3;
        vec++; if (GRANT !== 1'b0) begin err++; $display("FAIL rd_c0_grant: got %b want 0", GRANT); end
        tick(); EXT_REQ = 1'b0; EXT_ADDR = 16'h0000; #3;
        vec++; if (GRANT !== 1'b1) begin err++; $display("FAIL rd_c1_grant: got %b want 1", GRANT); end
        vec++; if ({MEM_RDN, MEM_WRN1, MEM_WRN0} !== 3'b011) begin err++; $display("FAIL rd_c1_strobes: got %b want 011", {MEM_RDN, MEM_WRN1, MEM_WRN0}); end
        vec++; if (MEM_ADDR !== 16'h1234) begin err++; $display("FAIL rd_c1_addr: got %h want 1234", MEM_ADDR); end
        vec++; if (EXT_ACK !== 1'b0) begin err++; $display("FAIL rd_c1_ack: got %b want 0", EXT_ACK); end
        tick(); MEM_DIN = 16'h0000; #3;
        vec++; if (EXT_ACK !== 1'b1 || GRANT !== 1'b0) begin err++; $display("FAIL rd_c2_ack: got ack=%b grant=%b want 1/0", EXT_ACK, GRANT); end
        vec++; if (EXT_RDATA !== 16'hBEEF) begin err++; $display("FAIL rd_c2_rdata: got %h want beef", EXT_RDATA); end
        tick(); #3;
        vec++; if (EXT_ACK !== 1'b0 || EXT_RDATA !== 16'hBEEF) begin err++; $display("FAIL rd_c3: got ack=%b rdata=%h want 0/beef", EXT_ACK, EXT_RDATA); end
    endtask

    task automatic test_byte_write();
        CORE_ADDR = 16'h8000; CORE_DOUT = 16'h1111;
        tick(); EXT_REQ = 1'b1; EXT_WE = 1'b1; EXT_BE = 2'b10; EXT_ADDR = 16'h0040; EXT_WDATA = 16'hA500; #3;
        tick(); EXT_REQ = 1'b0; EXT_WDATA = 16'h0000; #3;
        vec++; if (GRANT !== 1'b1) begin err++; $display("FAIL bw_grant: got %b want 1", GRANT); end
        vec++; if ({MEM_RDN, MEM_WRN1, MEM_WRN0} !== 3'b101) begin err++; $display("FAIL bw_strobes: got %b want 101", {MEM_RDN, MEM_WRN1, MEM_WRN0}); end
        vec++; if (MEM_DOUT !== 16'hA500 || MEM_ADDR !== 16'h0040) begin err++; $display("FAIL bw_bus: got %h@%h want a500@0040", MEM_DOUT, MEM_ADDR); end
        tick(); #3;
        vec++; if (EXT_ACK !== 1'b1) begin err++; $display("FAIL bw_ack: got %b want 1", EXT_ACK); end
        vec++; if (MEM_DOUT !== 16'h1111 || {MEM_RDN, MEM_WRN1, MEM_WRN0} !== 3'b111) begin err++; $display("FAIL bw_pass: got %h %b want 1111 111", MEM_DOUT, {MEM_RDN, MEM_WRN1, MEM_WRN0}); end
        vec++; if (EXT_RDATA !== 16'hBEEF) begin err++; $display("FAIL bw_rdata_kept: got %h want beef", EXT_RDATA); end
        tick();
    endtask

    task automatic test_be00_write();
        tick(); EXT_REQ = 1'b1; EXT_WE = 1'b1; EXT_BE = 2'b00; EXT_ADDR = 16'h0050; EXT_WDATA = 16'h00FF; #3;
        tick(); EXT_REQ = 1'b0; #3;
        vec++; if (GRANT !== 1'b1 || {MEM_RDN, MEM_WRN1, MEM_WRN0} !== 3'b111) begin err++; $display("FAIL be00_grant: got g=%b %b want 1 111", GRANT, {MEM_RDN, MEM_WRN1, MEM_WRN0}); end
        tick(); #3;
        vec++; if (EXT_ACK !== 1'b1) begin err++; $display("FAIL be00_ack: got %b want 1", EXT_ACK); end
        tick();
    endtask

    task automatic test_core_priority();
        tick(); EXT_REQ = 1'b1; EXT_WE = 1'b0; EXT_ADDR = 16'h2222; MEM_DIN = 16'h5A5A;
        CORE_RDN = 1'b0; CORE_ADDR = 16'h9000; #3;
        for (int i = 0; i < 3; i++) begin
            tick(); EXT_REQ = 1'b0; #3;
            vec++; if (GRANT !== 1'b0 || MEM_ADDR !== 16'h9000 || MEM_RDN !== 1'b0) begin
                err++; $display("FAIL prio_wait%0d: got g=%b addr=%h rdn=%b want 0/9000/0", i, GRANT, MEM_ADDR, MEM_RDN); end
        end
        tick(); CORE_RDN = 1'b1; #3;
        vec++; if (GRANT !== 1'b1 || MEM_ADDR !== 16'h2222 || MEM_RDN !== 1'b0) begin err++; $display("FAIL prio_grant: got g=%b addr=%h rdn=%b want 1/2222/0", GRANT, MEM_ADDR, MEM_RDN); end
        vec++; if (CORE_HOLD !== 1'b0) begin err++; $display("FAIL prio_nohold: got %b want 0", CORE_HOLD); end
        tick(); #3;
        vec++; if (EXT_ACK !== 1'b1 || EXT_RDATA !== 16'h5A5A) begin err++; $display("FAIL prio_ack: got ack=%b rdata=%h want 1/5a5a", EXT_ACK, EXT_RDATA); end
        tick();
    endtask

    task automatic test_starvation();
        tick(); EXT_REQ = 1'b1; EXT_WE = 1'b1; EXT_BE = 2'b11; EXT_ADDR = 16'h3333; EXT_WDATA = 16'h7777;
        CORE_RDN = 1'b0; CORE_ADDR = 16'h9000; #3;
        for (int i = 0; i < 4; i++) begin
            tick(); EXT_REQ = 1'b0; #3;
            vec++; if (GRANT !== 1'b0 || CORE_HOLD !== 1'b0) begin err++; $display("FAIL starve_pend%0d: got g=%b hold=%b want 0/0", i, GRANT, CORE_HOLD); end
        end
        for (int i = 0; i < 2; i++) begin
            tick(); #3;
            vec++; if (CORE_HOLD !== 1'b1 || GRANT !== 1'b0) begin err++; $display("FAIL starve_hold%0d: got hold=%b g=%b want 1/0", i, CORE_HOLD, GRANT); end
        end
        tick(); CORE_HELD = 1'b1; #3;
        vec++; if (GRANT !== 1'b1) begin err++; $display("FAIL starve_grant: got %b want 1", GRANT); end
        vec++; if ({MEM_RDN, MEM_WRN1, MEM_WRN0} !== 3'b100 || MEM_DOUT !== 16'h7777 || MEM_ADDR !== 16'h3333) begin
            err++; $display("FAIL starve_bus: got %b %h@%h want 100 7777@3333", {MEM_RDN, MEM_WRN1, MEM_WRN0}, MEM_DOUT, MEM_ADDR); end
        tick(); CORE_HELD = 1'b0; CORE_RDN = 1'b1; #3;
        vec++; if (EXT_ACK !== 1'b1 || CORE_HOLD !== 1'b0) begin err++; $display("FAIL starve_ack: got ack=%b hold=%b want 1/0", EXT_ACK, CORE_HOLD); end
        vec++; if (EXT_RDATA !== 16'h5A5A) begin err++; $display("FAIL starve_rdata: got %h want 5a5a", EXT_RDATA); end
        tick();
    endtask

    task automatic test_stopped();
        tick(); CORE_STOPPED = 1'b1; #3;
        vec++; if (ABUS_OEN !== 1'b1) begin err++; $display("FAIL stop_idle_oen: got %b want 1", ABUS_OEN); end
        tick(); EXT_REQ = 1'b1; EXT_WE = 1'b0; EXT_ADDR = 16'h4444; #3;
        tick(); EXT_REQ = 1'b0; #3;
        vec++; if (GRANT !== 1'b1 || ABUS_OEN !== 1'b0) begin err++; $display("FAIL stop_grant_oen: got g=%b oen=%b want 1/0", GRANT, ABUS_OEN); end
        tick(); #3;
        vec++; if (EXT_ACK !== 1'b1 || ABUS_OEN !== 1'b1) begin err++; $display("FAIL stop_ack_oen: got ack=%b oen=%b want 1/1", EXT_ACK, ABUS_OEN); end
        tick(); CORE_STOPPED = 1'b0;
    endtask

    task automatic test_reset_hold();
        tick(); EXT_REQ = 1'b1; EXT_WE = 1'b0; EXT_ADDR = 16'h6666; CORE_RDN = 1'b0; #3;
        for (int i = 0; i < 4; i++) begin
            tick(); EXT_REQ = 1'b0;
        end
        tick(); RESET = 1'b1; #3;
        vec++; if (CORE_HOLD !== 1'b1) begin err++; $display("FAIL rsth_inhold: got %b want 1", CORE_HOLD); end
        tick(); RESET = 1'b0; CORE_RDN = 1'b1; #3;
        vec++; if (CORE_HOLD !== 1'b0 || EXT_ACK !== 1'b0 || GRANT !== 1'b0) begin
            err++; $display("FAIL rsth_after: got hold=%b ack=%b g=%b want 0/0/0", CORE_HOLD, EXT_ACK, GRANT); end
        tick(); #3;
        vec++; if (EXT_ACK !== 1'b0 || GRANT !== 1'b0) begin err++; $display("FAIL rsth_idle: got ack=%b g=%b want 0/0", EXT_ACK, GRANT); end
        EXT_REQ = 1'b1; EXT_ADDR = 16'h5555; MEM_DIN = 16'h0F0F;
        tick(); EXT_REQ = 1'b0; #3;
        vec++; if (GRANT !== 1'b1 || MEM_ADDR !== 16'h5555) begin err++; $display("FAIL rsth_new_grant: got g=%b addr=%h want 1/5555", GRANT, MEM_ADDR); end
        tick(); #3;
        vec++; if (EXT_ACK !== 1'b1 || EXT_RDATA !== 16'h0F0F) begin err++; $display("FAIL rsth_new_ack: got ack=%b rdata=%h want 1/0f0f", EXT_ACK, EXT_RDATA); end
        tick();
    endtask

    task automatic test_back_to_back();
        tick(); EXT_REQ = 1'b1; EXT_WE = 1'b0; EXT_ADDR = 16'h7000; MEM_DIN = 16'h1357; #3;
        tick(); #3;
        vec++; if (GRANT !== 1'b1) begin err++; $display("FAIL b2b_grant1: got %b want 1", GRANT); end
        tick(); #3;
        vec++; if (EXT_ACK !== 1'b1 || GRANT !== 1'b0) begin err++; $display("FAIL b2b_ack1: got ack=%b g=%b want 1/0", EXT_ACK, GRANT); end
        tick(); #3;
        vec++; if (EXT_ACK !== 1'b0 || GRANT !== 1'b0) begin err++; $display("FAIL b2b_idle: got ack=%b g=%b want 0/0", EXT_ACK, GRANT); end
        tick(); #3;
        vec++; if (GRANT !== 1'b1) begin err++; $display("FAIL b2b_grant2: got %b want 1", GRANT); end
        tick(); EXT_REQ = 1'b0; #3;
        vec++; if (EXT_ACK !== 1'b1) begin err++; $display("FAIL b2b_ack2: got %b want 1", EXT_ACK); end
        tick();
    endtask

    initial begin
        test_reset();
        test_idle_read();
        test_byte_write();
        test_be00_write();
        test_core_priority();
        test_starvation();
        test_stopped();
        test_reset_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
